// File: rtl/axi_adapter_rd_arbiter_pkg.sv
// Shared types and helpers for the adapter read-side arbiter.
// The AR control fields travel as one packed payload.
package axi_adapter_rd_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } ar_state_t;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [2:0] prot;
  } ar_ctrl_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_adapter_rd_arbiter_arb_rr.sv
// N-way round-robin arbiter: combinational grant, registered last-grant pointer.
// The pointer only advances when the caller strobes update.
module axi_adapter_rd_arbiter_arb_rr
  import axi_adapter_rd_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic                    update,
  output logic [N-1:0]            grant_c,
  output logic [sel_width(N)-1:0] grant_idx_c,
  output logic                    grant_valid_c
);

  localparam int unsigned SEL_WIDTH = sel_width(N);

  logic [SEL_WIDTH-1:0] last_grant_q;

  // First requester strictly after the previous winner, wrapping.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant_q) + k) % N;
      if (!grant_valid_c && req[SEL_WIDTH'(idx)]) begin
        grant_valid_c               = 1'b1;
        grant_idx_c                 = SEL_WIDTH'(idx);
        grant_c[SEL_WIDTH'(idx)]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= SEL_WIDTH'(N - 1);
    end else if (update) begin
      last_grant_q <= grant_idx_c;
    end
  end

endmodule

// File: rtl/axi_adapter_rd_arbiter.sv
// Shares one width adapter's AR/R slave port between S_COUNT read masters.
// Grant order is kept in an in-order FIFO so R bursts route back to their issuer.
module axi_adapter_rd_arbiter
  import axi_adapter_rd_arbiter_pkg::*;
#(
  parameter int unsigned S_COUNT         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axi_arid,
  input  logic [S_COUNT*8-1:0]           s_axi_arlen,
  input  logic [S_COUNT*3-1:0]           s_axi_arsize,
  input  logic [S_COUNT*2-1:0]           s_axi_arburst,
  input  logic [S_COUNT*3-1:0]           s_axi_arprot,
  input  logic [S_COUNT-1:0]             s_axi_arvalid,
  output logic [S_COUNT-1:0]             s_axi_arready,
  output logic [ID_WIDTH-1:0]            s_axi_rid,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rlast,
  output logic [S_COUNT-1:0]             s_axi_rvalid,
  input  logic [S_COUNT-1:0]             s_axi_rready,
  output logic [ID_WIDTH-1:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  output logic [2:0]                     m_axi_arsize,
  output logic [1:0]                     m_axi_arburst,
  output logic [2:0]                     m_axi_arprot,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [ID_WIDTH-1:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rlast,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready
);

  localparam int unsigned SEL_WIDTH = $clog2(S_COUNT);
  localparam int unsigned PTR_WIDTH = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  ar_state_t             state_q, state_d;
  logic [S_COUNT-1:0]    grant_c;
  logic [SEL_WIDTH-1:0]  grant_idx_c;
  logic                  grant_valid_c;
  logic                  ar_accept_c;

  logic [ADDR_WIDTH-1:0] sel_addr_c, ar_addr_q;
  logic [ID_WIDTH-1:0]   sel_id_c, ar_id_q;
  ar_ctrl_t              sel_ctrl_c, ar_ctrl_q;
  logic                  ar_valid_q;

  logic [SEL_WIDTH-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  fifo_full_c, fifo_ne_c, fifo_pop_c;
  logic [SEL_WIDTH-1:0]  head_c;

  axi_adapter_rd_arbiter_arb_rr #(
    .N (S_COUNT)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .req           (s_axi_arvalid),
    .update        (ar_accept_c),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // Full comes from the registered count, so a same-cycle pop never frees a slot early.
  assign fifo_full_c = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));
  assign fifo_ne_c   = (count_q != '0);

  always_comb begin
    state_d       = state_q;
    ar_accept_c   = 1'b0;
    s_axi_arready = '0;
    case (state_q)
      ST_ARB: begin
        if (rst && grant_valid_c && !fifo_full_c) begin
          ar_accept_c   = 1'b1;
          s_axi_arready = grant_c;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_axi_arready) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_ARB;
    else      state_q <= state_d;
  end

  always_comb begin
    sel_addr_c = '0;
    sel_id_c   = '0;
    sel_ctrl_c = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (grant_idx_c == SEL_WIDTH'(i)) begin
        sel_addr_c       = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_id_c         = s_axi_arid[i*ID_WIDTH +: ID_WIDTH];
        sel_ctrl_c.len   = s_axi_arlen[i*8 +: 8];
        sel_ctrl_c.size  = s_axi_arsize[i*3 +: 3];
        sel_ctrl_c.burst = s_axi_arburst[i*2 +: 2];
        sel_ctrl_c.prot  = s_axi_arprot[i*3 +: 3];
      end
    end
  end

  // Fields load only on accept, so they are frozen for the whole HOLD phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_ctrl_q  <= '{len: 8'd0, size: 3'd0, burst: AXI_BURST_FIXED, prot: 3'd0};
    end else if (ar_accept_c) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= sel_addr_c;
      ar_id_q    <= sel_id_c;
      ar_ctrl_q  <= sel_ctrl_c;
    end else if (ar_valid_q && m_axi_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  assign m_axi_arvalid = ar_valid_q;
  assign m_axi_araddr  = ar_addr_q;
  assign m_axi_arid    = ar_id_q;
  assign m_axi_arlen   = ar_ctrl_q.len;
  assign m_axi_arsize  = ar_ctrl_q.size;
  assign m_axi_arburst = ar_ctrl_q.burst;
  assign m_axi_arprot  = ar_ctrl_q.prot;

  assign head_c       = fifo_mem[rd_ptr_q];
  assign m_axi_rready = fifo_ne_c & s_axi_rready[head_c];
  assign s_axi_rvalid = (m_axi_rvalid && fifo_ne_c) ? (S_COUNT'(1) << head_c) : '0;
  assign fifo_pop_c   = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  assign s_axi_rid   = m_axi_rid;
  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;

  always_ff @(posedge clk) begin
    if (ar_accept_c) fifo_mem[wr_ptr_q] <= grant_idx_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (ar_accept_c) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (fifo_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      case ({ar_accept_c, fifo_pop_c})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_adapter_rd_arbiter.sv
// Directed bench for axi_adapter_rd_arbiter with a queue-based reference model
// compared on every falling edge.
module tb_axi_adapter_rd_arbiter;

  localparam int S  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [S*AW-1:0] s_axi_araddr  = '0;
  logic [S*IW-1:0] s_axi_arid    = '0;
  logic [S*8-1:0]  s_axi_arlen   = '0;
  logic [S*3-1:0]  s_axi_arsize  = '0;
  logic [S*2-1:0]  s_axi_arburst = '0;
  logic [S*3-1:0]  s_axi_arprot  = '0;
  logic [S-1:0]    s_axi_arvalid = '0;
  logic [S-1:0]    s_axi_arready;
  logic [IW-1:0]   s_axi_rid;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic [S-1:0]    s_axi_rvalid;
  logic [S-1:0]    s_axi_rready  = '1;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arvalid;
  logic            m_axi_arready = 1'b1;
  logic [IW-1:0]   m_axi_rid     = '0;
  logic [DW-1:0]   m_axi_rdata   = '0;
  logic [1:0]      m_axi_rresp   = '0;
  logic            m_axi_rlast   = 1'b0;
  logic            m_axi_rvalid  = 1'b0;
  logic            m_axi_rready;

  axi_adapter_rd_arbiter #(
    .S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: last winner, in-flight grant queue, one pending AR slot.
  int            mdl_last;
  int            mdl_q[$];
  bit            mdl_busy;
  bit            mdl_valid;
  logic [AW-1:0] mdl_addr;
  logic [IW-1:0] mdl_id;
  logic [7:0]    mdl_len;
  logic [2:0]    mdl_size;
  logic [1:0]    mdl_burst;
  logic [2:0]    mdl_prot;
  int            mdl_win, mdl_c;
  bit            mdl_accept, mdl_pop, e_rready;
  logic [S-1:0]  e_arready, e_rvalid;

  always @(negedge clk) begin
    mdl_win = -1;
    for (int k = 1; k <= S; k++) begin
      mdl_c = (mdl_last + k) % S;
      if (mdl_win < 0 && s_axi_arvalid[mdl_c]) mdl_win = mdl_c;
    end
    mdl_accept = rst && !mdl_busy && (mdl_q.size() < MO) && (mdl_win >= 0);
    e_arready  = mdl_accept ? (S'(1) << mdl_win) : '0;
    e_rready   = 1'b0;
    e_rvalid   = '0;
    if (mdl_q.size() > 0) begin
      e_rready = s_axi_rready[mdl_q[0]];
      if (m_axi_rvalid) e_rvalid = S'(1) << mdl_q[0];
    end
    mdl_pop = m_axi_rvalid && e_rready && m_axi_rlast;

    if (mdl_valid) begin
      chk("arready",  64'(s_axi_arready), 64'(e_arready));
      chk("m_arvalid", 64'(m_axi_arvalid), 64'(mdl_busy));
      chk("m_araddr", 64'(m_axi_araddr), 64'(mdl_addr));
      chk("m_arid",   64'(m_axi_arid), 64'(mdl_id));
      chk("m_arlen",  64'(m_axi_arlen), 64'(mdl_len));
      chk("m_arsize", 64'(m_axi_arsize), 64'(mdl_size));
      chk("m_arburst", 64'(m_axi_arburst), 64'(mdl_burst));
      chk("m_arprot", 64'(m_axi_arprot), 64'(mdl_prot));
      chk("s_rvalid", 64'(s_axi_rvalid), 64'(e_rvalid));
      chk("m_rready", 64'(m_axi_rready), 64'(e_rready));
      chk("s_rdata",  64'(s_axi_rdata), 64'(m_axi_rdata));
      chk("s_rid",    64'(s_axi_rid), 64'(m_axi_rid));
      chk("s_rresp",  64'(s_axi_rresp), 64'(m_axi_rresp));
      chk("s_rlast",  64'(s_axi_rlast), 64'(m_axi_rlast));
    end

    if (!rst) begin
      mdl_last = S - 1;
      mdl_q.delete();
      mdl_busy = 1'b0;
      mdl_addr = '0; mdl_id = '0; mdl_len = '0;
      mdl_size = '0; mdl_burst = '0; mdl_prot = '0;
      mdl_valid = 1'b1;
    end else begin
      if (mdl_pop) void'(mdl_q.pop_front());
      if (mdl_busy && m_axi_arready) mdl_busy = 1'b0;
      if (mdl_accept) begin
        mdl_busy  = 1'b1;
        mdl_addr  = s_axi_araddr[mdl_win*AW +: AW];
        mdl_id    = s_axi_arid[mdl_win*IW +: IW];
        mdl_len   = s_axi_arlen[mdl_win*8 +: 8];
        mdl_size  = s_axi_arsize[mdl_win*3 +: 3];
        mdl_burst = s_axi_arburst[mdl_win*2 +: 2];
        mdl_prot  = s_axi_arprot[mdl_win*3 +: 3];
        mdl_last  = mdl_win;
        mdl_q.push_back(mdl_win);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                        input logic [7:0] len);
    s_axi_araddr[i*AW +: AW] = addr;
    s_axi_arid[i*IW +: IW]   = id;
    s_axi_arlen[i*8 +: 8]    = len;
    s_axi_arsize[i*3 +: 3]   = 3'd2;
    s_axi_arburst[i*2 +: 2]  = 2'b01;
    s_axi_arprot[i*3 +: 3]   = 3'(i);
  endtask

  task automatic wait_grant(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_axi_arready[i] && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("grant_wait", 64'(s_axi_arready[i]), 64'(1));
    tick();
  endtask

  task automatic issue(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                       input logic [7:0] len);
    set_ar(i, addr, id, len);
    s_axi_arvalid[i] = 1'b1;
    wait_grant(i);
    s_axi_arvalid[i] = 1'b0;
  endtask

  task automatic send_r(input int dest, input int beats, input logic [IW-1:0] id,
                        input logic [DW-1:0] base);
    int t;
    for (int b = 0; b < beats; b++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = base + 32'(b);
      m_axi_rid    = id;
      m_axi_rresp  = 2'(b);
      m_axi_rlast  = (b == beats - 1);
      t = 0;
      @(negedge clk);
      while (!m_axi_rready && t < 50) begin
        t++;
        @(negedge clk);
      end
      chk("r_route",  64'(s_axi_rvalid), 64'(S'(1) << dest));
      chk("r_accept", 64'(m_axi_rready), 64'(1));
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    @(negedge clk);
    chk({tag, "_rready"}, 64'(m_axi_rready), 64'(0));
    chk({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'(0));
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  int            order_q[$];
  int            gcyc_q[$];
  logic [IW-1:0] id_q[$];
  int            exp_ord [5] = '{0, 1, 2, 3, 0};
  logic [IW-1:0] exp_ids [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Round robin with all four masters requesting and one-beat responses streaming.
    m_axi_arready = 1'b1;
    for (int i = 0; i < S; i++) set_ar(i, AW'(32'h100 * i), IW'(8'hA0 + i), 8'd0);
    s_axi_arvalid = '1;
    m_axi_rvalid  = 1'b1;
    m_axi_rlast   = 1'b1;
    for (int t = 0; t < 40 && id_q.size() < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < S; i++)
        if (s_axi_arready[i]) begin
          order_q.push_back(i);
          gcyc_q.push_back(cyc);
        end
      if (m_axi_arvalid && m_axi_arready) id_q.push_back(m_axi_arid);
    end
    tick();
    s_axi_arvalid = '0;
    repeat (3) tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    chk("rr_count", 64'(order_q.size() >= 5 && id_q.size() >= 5), 64'(1));
    for (int k = 0; k < 5; k++) begin
      if (k < order_q.size()) chk("rr_order", 64'(order_q[k]), 64'(exp_ord[k]));
      if (k < id_q.size())    chk("rr_arid", 64'(id_q[k]), 64'(exp_ids[k]));
    end
    for (int k = 1; k < 5; k++)
      if (k < gcyc_q.size()) chk("rr_spacing", 64'(gcyc_q[k] - gcyc_q[k-1]), 64'(2));
    check_empty("rr_drained");

    // Single master 0, four-beat burst.
    m_axi_arready = 1'b0;
    set_ar(0, 32'h1000, 8'h11, 8'd3);
    s_axi_arvalid[0] = 1'b1;
    @(negedge clk);
    chk("single_arready", 64'(s_axi_arready), 64'(4'b0001));
    tick();
    s_axi_arvalid[0] = 1'b0;
    @(negedge clk);
    chk("single_arvalid", 64'(m_axi_arvalid), 64'(1));
    chk("single_araddr", 64'(m_axi_araddr), 64'(32'h1000));
    chk("single_arlen", 64'(m_axi_arlen), 64'(3));
    tick();
    m_axi_arready = 1'b1;
    tick();
    send_r(0, 4, 8'h11, 32'hD000_0000);
    check_empty("single_done");

    // Adapter stalls AR for ten cycles; master 3 waits behind it.
    m_axi_arready = 1'b0;
    set_ar(1, 32'h2000, 8'h21, 8'd5);
    s_axi_arvalid[1] = 1'b1;
    wait_grant(1);
    s_axi_arvalid[1] = 1'b0;
    set_ar(3, 32'h3000, 8'h33, 8'd0);
    s_axi_arvalid[3] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("stall_arvalid", 64'(m_axi_arvalid), 64'(1));
      chk("stall_araddr", 64'(m_axi_araddr), 64'(32'h2000));
      chk("stall_arlen", 64'(m_axi_arlen), 64'(5));
      chk("stall_arready", 64'(s_axi_arready), 64'(0));
    end
    tick();
    m_axi_arready = 1'b1;
    wait_grant(3);
    s_axi_arvalid[3] = 1'b0;
    send_r(1, 6, 8'h21, 32'h2000_0000);
    send_r(3, 1, 8'h33, 32'h3000_0000);

    // Fill all four slots, then a fifth request waits for the first pop.
    issue(0, 32'h4000, 8'h40, 8'd0);
    issue(1, 32'h4100, 8'h41, 8'd0);
    issue(2, 32'h4200, 8'h42, 8'd0);
    issue(3, 32'h4300, 8'h43, 8'd0);
    set_ar(0, 32'h4444, 8'h44, 8'd0);
    s_axi_arvalid[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("full_block", 64'(s_axi_arready), 64'(0));
    end
    tick();
    send_r(0, 1, 8'h40, 32'h4000_0000);
    @(negedge clk);
    chk("accept_after_pop", 64'(s_axi_arready), 64'(4'b0001));
    tick();
    s_axi_arvalid[0] = 1'b0;
    send_r(1, 1, 8'h41, 32'h4100_0000);
    send_r(2, 1, 8'h42, 32'h4200_0000);
    send_r(3, 1, 8'h43, 32'h4300_0000);
    send_r(0, 1, 8'h44, 32'h4400_0000);

    // Master 2 then master 1; master 2 back-pressures R for three cycles.
    issue(2, 32'h5000, 8'h52, 8'd1);
    issue(1, 32'h6000, 8'h61, 8'd0);
    s_axi_rready = 4'b1011;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = 32'h55;
    m_axi_rid    = 8'h52;
    m_axi_rlast  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("rstall_rready", 64'(m_axi_rready), 64'(0));
      chk("rstall_rvalid", 64'(s_axi_rvalid), 64'(4'b0100));
    end
    tick();
    s_axi_rready = '1;
    send_r(2, 2, 8'h52, 32'h5000_0000);
    send_r(1, 1, 8'h61, 32'h6000_0000);

    // Reset with two bursts outstanding, then master 0 must win first.
    issue(0, 32'h7000, 8'h70, 8'd0);
    issue(1, 32'h7100, 8'h71, 8'd0);
    rst = 1'b0;
    set_ar(2, 32'h7200, 8'h72, 8'd0);
    s_axi_arvalid[2] = 1'b1;
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_arready", 64'(s_axi_arready), 64'(0));
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
    chk("rst_rready", 64'(m_axi_rready), 64'(0));
    tick();
    rst = 1'b1;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    set_ar(0, 32'h8000, 8'h80, 8'd0);
    s_axi_arvalid[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(s_axi_arready), 64'(4'b0001));
    tick();
    s_axi_arvalid[0] = 1'b0;
    wait_grant(2);
    s_axi_arvalid[2] = 1'b0;
    send_r(0, 1, 8'h80, 32'h8000_0000);
    send_r(2, 1, 8'h72, 32'h7200_0000);
    check_empty("final");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
